// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types and constants for the idli UART receiver
package idli_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } urx_state_t;

  // Nibble carried on the core's 4-bit datapath
  typedef logic [3:0] sqi_data_t;

  localparam int URX_BITS = 8;

  // Select the low or high nibble of a received byte
  function automatic sqi_data_t urx_nibble(input logic [URX_BITS-1:0] byte_in,
                                           input logic              hi);
    return hi ? byte_in[7:4] : byte_in[3:0];
  endfunction

endpackage

// File: rtl/idli_urx_fifo_m.sv
// rtl/idli_urx_fifo_m.sv - byte FIFO with wrap-around pointers and an extra pointer bit
module idli_urx_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [URX_BITS-1:0] i_data,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [URX_BITS-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [URX_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic                w_do_pop;
  logic                w_do_push;

  // Pointers match entirely when empty, differ only in the wrap bit when full
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer advance on accepted push/pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/idli_uart_rx_m.sv
// rtl/idli_uart_rx_m.sv - UART 8N1 receiver, nibble-serial word return; IDLI_UART_RX_FRAME_ERR_EN enables stop-bit checking
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      i_urx_gck,
  input  logic      i_urx_rst,
  input  logic      i_urx_rx,
  input  logic      i_urx_rd,
  output logic      o_urx_stall,
  output logic [3:0] o_urx_data,
  output logic      o_urx_overflow,
  output logic      o_urx_frame_err,
  input  logic      i_urx_clr
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  logic                r_rx_meta;
  logic                r_rx_sync;
  logic                r_rx_prev;
  urx_state_t          r_state;
  logic [BW-1:0]       r_baud;
  logic [2:0]          r_bit_cnt;
  logic [URX_BITS-1:0] r_shift;
  logic                r_busy;
  logic [1:0]          r_phase;
  sqi_data_t           r_hi;
  logic                r_overflow;

  logic                w_stop_sample;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [URX_BITS-1:0] w_head;
  logic                w_rd_start;
  logic                w_ovf_set;
  sqi_data_t           w_data;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_urx_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Frame FSM: half-bit to mid start bit, then one full bit per data/stop sample
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_state <= START;
            r_baud  <= BAUD_HALF;
          end
        end
        START: begin
          if (r_baud == '0) begin
            r_baud    <= BAUD_FULL;
            r_bit_cnt <= '0;
            r_state   <= r_rx_sync ? IDLE : DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        DATA: begin
          if (r_baud == '0) begin
            r_baud    <= BAUD_FULL;
            r_shift   <= {r_rx_sync, r_shift[URX_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        STOP: begin
          if (r_baud == '0) begin
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_stop_sample = (r_state == STOP) && (r_baud == '0);

`ifdef IDLI_UART_RX_FRAME_ERR_EN
  logic r_frame_err;
  logic w_frame_bad;

  assign w_push      = w_stop_sample && r_rx_sync;
  assign w_frame_bad = w_stop_sample && !r_rx_sync;

  // Sticky framing error; a new error beats a simultaneous clear
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
    end else if (i_urx_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  assign o_urx_frame_err = r_frame_err;
`else
  assign w_push          = w_stop_sample;
  assign o_urx_frame_err = 1'b0;
`endif

  idli_urx_fifo_m #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_urx_gck),
    .i_rst   (i_urx_rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_rd_start),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_rd_start = i_urx_rd && !w_empty && !r_busy;
  assign w_ovf_set  = w_push && w_full && !w_rd_start;

  // Read sequencer: pop on start, then emit high nibble and two zero nibbles
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      r_busy  <= 1'b0;
      r_phase <= '0;
      r_hi    <= '0;
    end else if (w_rd_start) begin
      r_busy  <= 1'b1;
      r_phase <= 2'd1;
      r_hi    <= urx_nibble(w_head, 1'b1);
    end else if (r_busy) begin
      r_phase <= r_phase + 1'b1;
      if (r_phase == 2'd3) r_busy <= 1'b0;
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear
  always_ff @(posedge i_urx_gck or posedge i_urx_rst) begin
    if (i_urx_rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (i_urx_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Nibble mux: low nibble straight from the FIFO head on the start cycle
  always_comb begin
    w_data = '0;
    if (w_rd_start) begin
      w_data = urx_nibble(w_head, 1'b0);
    end else if (r_busy && (r_phase == 2'd1)) begin
      w_data = r_hi;
    end
  end

  assign o_urx_data     = w_data;
  assign o_urx_stall    = i_urx_rd && w_empty;
  assign o_urx_overflow = r_overflow;

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// tb/tb_idli_uart_rx_m.sv - directed self-checking bench for idli_uart_rx_m
module tb_idli_uart_rx_m;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr;
  logic       stall;
  logic [3:0] data;
  logic       overflow;
  logic       frame_err;

  int n_checks;
  int n_errors;

  idli_uart_rx_m #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_urx_gck       (clk),
    .i_urx_rst       (rst),
    .i_urx_rx        (rx),
    .i_urx_rd        (rd),
    .o_urx_stall     (stall),
    .o_urx_data      (data),
    .o_urx_overflow  (overflow),
    .o_urx_frame_err (frame_err),
    .i_urx_clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (nbits == 8) begin
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_word(input string tag, input logic [7:0] b,
                           output int stall_cycles, output logic zero_ok);
    stall_cycles = 0;
    zero_ok      = 1'b1;
    @(negedge clk);
    rd = 1'b1;
    #1;
    while (stall && stall_cycles < 200) begin
      if (data !== 4'h0) zero_ok = 1'b0;
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_released"}, 32'(stall), 32'd0);
    check({tag, "_n0"}, 32'(data), 32'(b[3:0]));
    @(negedge clk);
    rd = 1'b0;
    #1;
    check({tag, "_n1"}, 32'(data), 32'(b[7:4]));
    @(negedge clk);
    #1;
    check({tag, "_n2"}, 32'(data), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_n3"}, 32'(data), 32'd0);
  endtask

  task automatic probe_empty(input string tag);
    @(negedge clk);
    rd = 1'b1;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd1);
    check({tag, "_data0"}, 32'(data), 32'd0);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  int   sc;
  logic zok;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    clr = 1'b0;
    idle(3);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // 1: single frame, then a read
    send_frame(8'hA5, 1'b1, 8);
    idle(6);
    read_word("t1", 8'hA5, sc, zok);
    check("t1_never_stalled", 32'(sc), 32'd0);
    idle(2);
    #1;
    check("t1_idle_data", 32'(data), 32'd0);

    // 2: read held on empty FIFO until a byte lands
    fork
      send_frame(8'h3C, 1'b1, 8);
      read_word("t2", 8'h3C, sc, zok);
    join
    check("t2_stalled", 32'(sc > 0), 32'd1);
    check("t2_data_zero_while_stalled", 32'(zok), 32'd1);
    idle(4);

    // 3: overflow on fifth frame
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 8);
    idle(6);
    #1;
    check("t3_no_ovf_at_full", 32'(overflow), 32'd0);
    send_frame(8'h05, 1'b1, 8);
    idle(6);
    #1;
    check("t3_ovf_set", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      read_word($sformatf("t3_rd%0d", k), 8'(k), sc, zok);
    end
    probe_empty("t3_fifth_dropped");
    #1;
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check("t3_ovf_cleared", 32'(overflow), 32'd0);

    // 4: one-cycle glitch on idle line
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(20);
    probe_empty("t4_glitch");
    send_frame(8'h5A, 1'b1, 8);
    idle(6);
    read_word("t4_after", 8'h5A, sc, zok);

    // 5: bad stop bit
    send_frame(8'h77, 1'b0, 8);
    idle(6);
    #1;
`ifdef IDLI_UART_RX_FRAME_ERR_EN
    check("t5_frame_err", 32'(frame_err), 32'd1);
    probe_empty("t5_dropped");
    pulse_clr();
    check("t5_frame_err_cleared", 32'(frame_err), 32'd0);
`else
    check("t5_frame_err_tied", 32'(frame_err), 32'd0);
    read_word("t5", 8'h77, sc, zok);
`endif
    idle(4);

    // 6: reset mid-frame
    for (int k = 1; k <= 5; k++) send_frame(8'h40 + 8'(k), 1'b1, 8);
    idle(6);
    #1;
    check("t6_ovf_before_rst", 32'(overflow), 32'd1);
    send_frame(8'hFF, 1'b1, 4);
    rst = 1'b1;
    rx  = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    check("t6_ovf_after_rst", 32'(overflow), 32'd0);
    check("t6_ferr_after_rst", 32'(frame_err), 32'd0);
    idle(10);
    probe_empty("t6_empty");
    send_frame(8'h12, 1'b1, 8);
    idle(6);
    read_word("t6", 8'h12, sc, zok);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
